// File: rtl/barrido_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
// Holds the FSM state encoding and the lowest-set-column priority encoder.
package barrido_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        REPORT,
        RELEASE_DB
    } estado_t;

    localparam int unsigned MAX_COLS = 32;

    function automatic logic [4:0] lowest_set(input logic [MAX_COLS-1:0] col);
        lowest_set = '0;
        for (int i = MAX_COLS - 1; i >= 0; i--) begin
            if (col[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/anillo_param.sv
// Parametrised one-hot ring counter; loads 0..01 on reset and only rotates,
// so exactly one bit is ever set.
module anillo_param #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= N'(1);
        end else if (advance) begin
            r_q <= {r_q[N-2:0], r_q[N-1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/barrido_teclado.sv
// Matrix-keypad scanner: rotating row drive, debounced press/release,
// one key code per press over a valid/ready handshake.
module barrido_teclado
    import barrido_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 4,
    parameter  int DEBOUNCE   = 3,
    parameter  bit ACTIVE_LOW = 1'b0,
    localparam int KW         = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] fila,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [COLS-1:0] r_sync1;
    logic [COLS-1:0] r_sync2;
    logic [DW-1:0]   r_div;
    estado_t         r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_col;
    logic [KW-1:0]   r_key_code;
    logic            r_key_valid;

    logic [COLS-1:0] w_colh;
    logic [ROWS-1:0] w_ring;
    logic [4:0]      w_low;
    logic [KW-1:0]   w_code;
    logic            w_tick;
    logic            w_any;
    logic            w_hit;
    logic            w_done;
    logic            w_adv;
    int              w_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_colh = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == DW'(SCAN_DIV - 1)) ? '0 : r_div + 1'b1;
        end
    end

    assign w_tick = en && (r_div == DW'(SCAN_DIV - 1));
    assign w_any  = |w_colh;
    assign w_low  = lowest_set(MAX_COLS'(w_colh));
    assign w_hit  = |(w_colh & (COLS'(1) << r_col));
    assign w_done = (r_cnt == CW'(DEBOUNCE));

    // Ring only moves while idle-scanning or when a press is rejected as bounce
    always_comb begin
        w_adv = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                SCAN:     w_adv = !w_any;
                PRESS_DB: w_adv = !w_done && !w_hit;
                default:  w_adv = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_row = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (w_ring[i]) w_row = i;
        end
    end

    assign w_code = KW'(w_row * COLS + int'(r_col));

    anillo_param #(
        .N(ROWS)
    ) u_anillo (
        .clk    (clk),
        .rst    (rst),
        .advance(w_adv),
        .q      (w_ring)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SCAN;
            r_cnt       <= '0;
            r_col       <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            unique case (r_state)
                SCAN: begin
                    if (w_tick && w_any) begin
                        r_state <= PRESS_DB;
                        r_col   <= w_low;
                        r_cnt   <= CW'(1);
                    end
                end
                PRESS_DB: begin
                    if (w_done) begin
                        r_state     <= REPORT;
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_code;
                    end else if (w_tick) begin
                        if (w_hit) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_state <= SCAN;
                            r_cnt   <= '0;
                        end
                    end
                end
                REPORT: begin
                    if (r_key_valid && key_ready) begin
                        r_key_valid <= 1'b0;
                        r_state     <= RELEASE_DB;
                        r_cnt       <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (w_tick) begin
                        if (w_any) begin
                            r_cnt <= '0;
                        end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                            r_state <= SCAN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign fila      = ACTIVE_LOW ? ~w_ring : w_ring;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_barrido_teclado.sv
// Directed bench for barrido_teclado with a reactive keypad model
// (active-high instance and active-low instance).
module tb_barrido_teclado;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] col_in0, col_in1;
    logic [3:0] fila0, fila1;
    logic [3:0] code0, code1;
    logic       valid0, valid1;
    logic       ready0, ready1;

    logic       kp0_on, kp1_on;
    logic [3:0] kp0_row, kp0_col, kp1_row, kp1_col;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // A key closes its column only while its row is being driven
    assign col_in0 = (kp0_on && |(fila0 & kp0_row)) ? kp0_col : 4'b0000;
    assign col_in1 = (kp1_on && |(~fila1 & kp1_row)) ? ~kp1_col : 4'b1111;

    barrido_teclado #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .col_in(col_in0), .fila(fila0),
        .key_code(code0), .key_valid(valid0), .key_ready(ready0)
    );

    barrido_teclado #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .col_in(col_in1), .fila(fila1),
        .key_code(code1), .key_valid(valid1), .key_ready(ready1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_fila(input logic [3:0] exp, input int budget, input string tag);
        int n = 0;
        while (fila0 !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(fila0), 32'(exp));
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (valid0 !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(valid0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, held, vb;
        logic [31:0] e;
        rst = 1'b1; en = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        kp0_on = 1'b0; kp0_row = '0; kp0_col = '0;
        kp1_on = 1'b0; kp1_row = '0; kp1_col = '0;
        repeat (3) @(negedge clk);
        chk("rst_fila0", 32'(fila0), 32'h1);
        chk("rst_valid0", 32'(valid0), 32'h0);
        chk("rst_code0", 32'(code0), 32'h0);
        chk("rst_fila1", 32'(fila1), 32'he);
        chk("rst_valid1", 32'(valid1), 32'h0);
        rst = 1'b0;

        repeat (12) @(negedge clk);
        chk("en_hold", 32'(fila0), 32'h1);
        en = 1'b1;

        for (int i = 0; i < 20; i++) begin
            e = 32'd1 << ((i / 4) % 4);
            chk("scan", 32'(fila0), e);
            chk("scan_valid", 32'(valid0), 32'h0);
            @(negedge clk);
        end

        // Key row1/col2, measure latency from row entry
        wait_fila(4'b0001, 40, "s2_row0");
        kp0_row = 4'b0010; kp0_col = 4'b0100; kp0_on = 1'b1;
        wait_fila(4'b0010, 10, "s2_row1");
        n = 0;
        while (valid0 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("s2_latency", 32'(n), 32'd13);
        chk("s2_code", 32'(code0), 32'd6);
        chk("s2_fila", 32'(fila0), 32'h2);
        ready0 = 1'b1;
        acc = 0;
        repeat (30) begin
            if (valid0 && ready0) acc++;
            @(negedge clk);
        end
        chk("s2_accepts", 32'(acc), 32'd1);
        kp0_on = 1'b0;
        wait_fila(4'b0100, 40, "s2_resume");

        // Key row0/col0 held with consumer stalled
        ready0 = 1'b0;
        wait_fila(4'b1000, 20, "s3_row3");
        kp0_row = 4'b0001; kp0_col = 4'b0001; kp0_on = 1'b1;
        wait_valid(80, "s3_valid");
        chk("s3_code", 32'(code0), 32'd0);
        held = 0;
        repeat (20) begin
            if (valid0 && code0 == 4'd0) held++;
            @(negedge clk);
        end
        chk("s3_held", 32'(held), 32'd20);
        ready0 = 1'b1;
        acc = 0;
        repeat (10) begin
            if (valid0 && ready0) acc++;
            @(negedge clk);
        end
        chk("s3_accepts", 32'(acc), 32'd1);
        kp0_on = 1'b0;
        n = 0;
        while (fila0 === 4'b0001 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("s3_release_gap", 32'(n >= 14 && n <= 19), 32'd1);
        chk("s3_next_row", 32'(fila0), 32'h2);

        // One-tick bounce in row2
        wait_fila(4'b0100, 20, "s4_row2");
        kp0_row = 4'b0100; kp0_col = 4'b1000; kp0_on = 1'b1;
        n = 0; vb = 0;
        while (fila0 === 4'b0100 && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 4) kp0_on = 1'b0;
            if (valid0) vb = 1;
        end
        chk("s4_dwell", 32'(n), 32'd8);
        chk("s4_next_row", 32'(fila0), 32'h8);
        chk("s4_no_valid", 32'(vb), 32'd0);

        // Two columns in row3: lowest column wins
        wait_fila(4'b0001, 20, "s5_row0");
        kp0_row = 4'b1000; kp0_col = 4'b1010; kp0_on = 1'b1;
        wait_valid(60, "s5_valid");
        chk("s5_code", 32'(code0), 32'd13);
        repeat (2) @(negedge clk);
        chk("s5_accepted", 32'(valid0), 32'd0);
        kp0_on = 1'b0;
        wait_fila(4'b0001, 40, "s5_resume");

        // Async reset while a key is pending
        ready0 = 1'b0;
        kp0_row = 4'b0010; kp0_col = 4'b0100; kp0_on = 1'b1;
        wait_valid(60, "s6_valid");
        #1 rst = 1'b1;
        #1;
        chk("s6_valid_clr", 32'(valid0), 32'd0);
        chk("s6_fila", 32'(fila0), 32'h1);
        chk("s6_code", 32'(code0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        kp0_on = 1'b0;

        // Active-low instance, key row1/col2
        kp1_row = 4'b0010; kp1_col = 4'b0100; kp1_on = 1'b1;
        n = 0;
        while (valid1 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("al_valid", 32'(valid1), 32'd1);
        chk("al_code", 32'(code1), 32'd6);
        chk("al_fila", 32'(fila1), 32'hd);
        ready1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("al_accepted", 32'(valid1), 32'd0);
        chk("al_valid0_idle", 32'(valid0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
